riscv_rspbuf: RTL and testbench
===============================

Name: riscv_rspbuf

Overview:
Memory-response buffer on the return path from the memory system (BIU) to the CPU load/fetch pipeline. It tracks issued-but-unacknowledged requests and accepts responses (data plus error) in order. It holds responses while the pipeline is stalled and discards responses belonging to requests killed by a flush. Credit output ready_o throttles the request side so the buffer can never overflow.

Parameters:
DEPTH, 2, response queue entries; also the maximum number of outstanding requests plus buffered responses.
DBITS, 32, response data width.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; asynchronous, active-low
clr_i  input  1  flush: kill all in-flight and buffered responses
ena_i  input  1  pipeline consumes ack_o/q_o this cycle (not stalled)
req_i  input  1  request accepted by memory system this cycle
ack_i  input  1  memory response valid this cycle
d_i  input  DBITS  response data
err_i  input  1  response bus error, qualified by ack_i
ack_o  output  1  response valid towards CPU
q_o  output  DBITS  response data towards CPU
err_o  output  1  response error towards CPU
ready_o  output  1  a further request may be issued
empty_o  output  1  queue empty
full_o  output  1  queue full

Behaviour:
- Reset values: ack_o=0, err_o=0, ready_o=1, empty_o=1, full_o=0, all counters 0.
- q_o is don't-care when ack_o=0; the bench must not check it.
- pending: width $clog2(DEPTH)+1; +1 on req_i, -1 on ack_i, unchanged when both are set.
- discard: same width; counts in-flight responses that will be dropped.
- accept = ack_i & (discard==0) & ~clr_i.
- On ack_i with discard>0 and no clr_i: response is dropped and discard decrements.
- On clr_i: discard <= pending_next, where pending_next includes a same-cycle req_i and excludes a same-cycle ack_i. The queue is cleared. ack_o is forced to 0 that cycle.
- Bypass path:
  - ack_o = ~clr_i & (~empty_o | accept).
  - q_o/err_o = empty_o ? d_i/err_i : queue head.
  - Zero latency when the queue is empty.
- Queue write: accept & ~(empty_o & ena_i).
- Queue read: ena_i & ~empty_o & ~clr_i.
- Simultaneous read and write on a non-empty queue keeps order: the head is popped and the new entry is appended.
- ready_o = (pending + queue_count + discard_pending_that_may_land) < DEPTH. Discarded responses occupy credit until they arrive. Combinational; it may drop in the same cycle as req_i.
- Any response still awaiting acceptance holds its credit while ena_i=0.
- Protocol violations: the following fire a simulation assertion. The first is ignored in RTL.
  - ack_i with pending==0
  - req_i with ready_o==0
  - write to a full queue
- The fill counter wraps only via the queue pointers; no arithmetic wrap is permitted. This is guaranteed by the ready_o credit.
- Reset mid-operation: everything returns to reset values immediately, asynchronously. In-flight responses arriving after reset are protocol violations; the system resets the BIU together with this block.

Decomposition:
- Sub-module: the existing rl_queue, width DBITS+1 ({err,data}), DEPTH entries. It supplies clr_i, empty_o, full_o and the count.
- No new typedefs. Any error-encoding constants come from biu_constants_pkg.
- Counters and credit logic are local.

Test Plan:
- Single read, ena_i=1: req_i at cycle 0, ack_i with d_i=0xDEADBEEF at cycle 2 -> ack_o=1 and q_o=0xDEADBEEF in cycle 2, empty_o stays 1, ready_o=1 again after cycle 2.
- Stall buffering, DEPTH=2, ena_i=0:
  - Stimulus: two reqs, acks with 0x11 then 0x22.
  - Then: full_o=1 and ready_o=0.
  - Next: raise ena_i.
  - Required response: ack_o with q_o=0x11, then 0x22 on consecutive cycles, empty_o=1.
- Flush with in-flight requests:
  - Stimulus: 2 reqs outstanding, then clr_i for one cycle, then 2 acks (0xAA, 0xBB).
  - Required response: ack_o stays 0 throughout, discard returns to 0.
  - Follow-up: a new req/ack with 0xCC produces ack_o=1, q_o=0xCC.
- clr_i coincident with req_i and with ack_i:
  - Stimulus: 1 outstanding, same cycle has ack_i=1, req_i=1, clr_i=1.
  - Required response: no ack_o; discard=1; the next ack_i is dropped.
- Error propagation: ack_i with err_i=1 while the queue holds 1 entry and ena_i=0 -> after draining, the second ack_o has err_o=1 and the first has err_o=0.
- Back-to-back streaming, ena_i=1: req_i and ack_i on every cycle for 16 cycles with incrementing data -> ack_o=1 every cycle, q_o matches in order, queue never written.

Source files
------------

// File: rtl/riscv_rspbuf_pkg.sv
// Shared constants for the memory-response buffer.
// Holds the default queue depth and data width, plus a helper that gives the
// width of the outstanding/discard counters for a given depth.
package riscv_rspbuf_pkg;

    localparam int unsigned RSPBUF_DEPTH = 2;
    localparam int unsigned RSPBUF_DBITS = 32;

    // Counters must be able to hold the value DEPTH itself.
    function automatic int unsigned rspbuf_cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rl_queue.sv
// Small circular FIFO with synchronous clear.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          drop all entries (wins over we_i/re_i)
//   we_i, d_i      append d_i at the tail
//   re_i           pop the head
//   q_o            head entry (meaningless when empty_o=1)
//   empty_o/full_o occupancy flags
//   count_o        number of stored entries
module rl_queue #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             re_i,
    output logic [WIDTH-1:0] q_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (we_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (re_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (we_i && !re_i)      count_q <= count_q + CW'(1);
            else if (!we_i && re_i) count_q <= count_q - CW'(1);
        end
    end

    // Storage needs no reset; entries are only observed once written.
    always_ff @(posedge clk_i) begin
        if (we_i && !clr_i) mem_q[wr_ptr_q] <= d_i;
    end

    assign q_o     = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;

endmodule

// File: rtl/riscv_rspbuf.sv
// Memory-response buffer between the BIU and the CPU load/fetch pipeline.
// Tracks outstanding requests, bypasses responses straight through when the
// pipeline is running and the queue is empty, buffers them while stalled,
// and silently drops responses whose requests were killed by a flush.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           flush: kill in-flight and buffered responses
//   ena_i           pipeline consumes ack_o/q_o this cycle
//   req_i           request accepted by the memory system
//   ack_i,d_i,err_i memory response
//   ack_o,q_o,err_o response towards the CPU (q_o/err_o valid with ack_o)
//   ready_o         credit: another request may be issued
//   empty_o,full_o  queue occupancy
// Handshake: a response is presented while ack_o=1 and is consumed in the
// cycle where ack_o=1 and ena_i=1; otherwise it stays presented.
module riscv_rspbuf
    import riscv_rspbuf_pkg::*;
#(
    parameter int unsigned DEPTH = RSPBUF_DEPTH,
    parameter int unsigned DBITS = RSPBUF_DBITS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             ena_i,
    input  logic             req_i,
    input  logic             ack_i,
    input  logic [DBITS-1:0] d_i,
    input  logic             err_i,
    output logic             ack_o,
    output logic [DBITS-1:0] q_o,
    output logic             err_o,
    output logic             ready_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned  CW      = rspbuf_cnt_width(DEPTH);
    localparam logic [CW:0]  DEPTH_C = (CW + 1)'(DEPTH);

    logic [CW-1:0] pending_q, pending_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count;
    logic [CW:0]   credit;
    logic          accept, q_we, q_re;
    logic [DBITS:0] head;

    assign accept = ack_i & (discard_q == '0) & ~clr_i;
    assign q_we   = accept & ~(empty_o & ena_i);
    assign q_re   = ena_i & ~empty_o & ~clr_i;

    rl_queue #(
        .WIDTH (DBITS + 1),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .we_i    (q_we),
        .d_i     ({err_i, d_i}),
        .re_i    (q_re),
        .q_o     (head),
        .empty_o (empty_o),
        .full_o  (full_o),
        .count_o (count)
    );

    always_comb begin
        pending_d = pending_q;
        if (req_i && !ack_i)      pending_d = pending_q + CW'(1);
        else if (!req_i && ack_i) pending_d = pending_q - CW'(1);
    end

    // A flush turns every request still in flight after this cycle into a
    // response to drop; a same-cycle ack is already accounted for.
    always_comb begin
        discard_d = discard_q;
        if (clr_i)                              discard_d = pending_d;
        else if (ack_i && (discard_q != '0))    discard_d = discard_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            discard_q <= '0;
        end else begin
            pending_q <= pending_d;
            discard_q <= discard_d;
        end
    end

    assign ack_o = ~clr_i & (~empty_o | accept);
    assign q_o   = empty_o ? d_i   : head[DBITS-1:0];
    assign err_o = empty_o ? err_i : head[DBITS];

    // Responses to be dropped are still counted in pending, so they keep
    // their credit until they actually arrive.
    assign credit  = {1'b0, pending_q} + {1'b0, count};
    assign ready_o = (credit < DEPTH_C);

    a_ack_outstanding : assert property (
        @(posedge clk_i) disable iff (!rst_ni) ack_i |-> (pending_q != '0));
    a_req_credit : assert property (
        @(posedge clk_i) disable iff (!rst_ni) req_i |-> ready_o);
    a_no_overflow : assert property (
        @(posedge clk_i) disable iff (!rst_ni) (q_we && !q_re) |-> !full_o);

endmodule

// File: tb/tb_riscv_rspbuf.sv
// Directed bench for riscv_rspbuf. Expected responses are pushed into a
// queue when stimulus is applied; a monitor pops one whenever the DUT
// presents a response that the pipeline consumes.
module tb_riscv_rspbuf;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clr_i, ena_i, req_i, ack_i, err_i;
    logic [31:0] d_i;
    logic        ack_o, err_o, ready_o, empty_o, full_o;
    logic [31:0] q_o;

    logic [32:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    // clock / reset
    always #5 clk_i = ~clk_i;

    riscv_rspbuf #(.DEPTH(2), .DBITS(32)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .ena_i   (ena_i),
        .req_i   (req_i),
        .ack_i   (ack_i),
        .d_i     (d_i),
        .err_i   (err_i),
        .ack_o   (ack_o),
        .q_o     (q_o),
        .err_o   (err_o),
        .ready_o (ready_o),
        .empty_o (empty_o),
        .full_o  (full_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; returns at the falling edge with the
    // inputs still applied so combinational outputs can be checked.
    task automatic cyc(input logic r, input logic a, input logic [31:0] d,
                       input logic e, input logic en, input logic c);
        @(posedge clk_i);
        #1;
        req_i = r; ack_i = a; d_i = d; err_i = e; ena_i = en; clr_i = c;
        @(negedge clk_i);
    endtask

    task automatic idle(input logic en);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, en, 1'b0);
    endtask

    // scoreboard monitor
    always @(negedge clk_i) begin
        if (rst_ni && ack_o && ena_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got err=%b q=%h expected no response", err_o, q_o);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({err_o, q_o} !== e) begin
                    bad++;
                    $display("FAIL rsp: got err=%b q=%h expected err=%b q=%h",
                             err_o, q_o, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        clr_i = 0; ena_i = 0; req_i = 0; ack_i = 0; err_i = 0; d_i = '0;
        #2;
        chk("rst_ack_o",   {31'b0, ack_o},   32'd0);
        chk("rst_err_o",   {31'b0, err_o},   32'd0);
        chk("rst_ready_o", {31'b0, ready_o}, 32'd1);
        chk("rst_empty_o", {31'b0, empty_o}, 32'd1);
        chk("rst_full_o",  {31'b0, full_o},  32'd0);
        #20;
        rst_ni = 1'b1;

        // single read, zero-latency bypass
        cyc(1, 0, 32'h0, 0, 1, 0);
        idle(1);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        cyc(0, 1, 32'hDEADBEEF, 0, 1, 0);
        chk("single_ack_o",   {31'b0, ack_o},   32'd1);
        chk("single_empty_o", {31'b0, empty_o}, 32'd1);
        idle(1);
        chk("single_ready_o", {31'b0, ready_o}, 32'd1);

        // stall buffering
        cyc(1, 0, 32'h0, 0, 0, 0);
        cyc(1, 0, 32'h0, 0, 0, 0);
        exp_q.push_back({1'b0, 32'h11});
        cyc(0, 1, 32'h11, 0, 0, 0);
        exp_q.push_back({1'b0, 32'h22});
        cyc(0, 1, 32'h22, 0, 0, 0);
        idle(0);
        chk("stall_full_o",  {31'b0, full_o},  32'd1);
        chk("stall_ready_o", {31'b0, ready_o}, 32'd0);
        chk("stall_ack_o",   {31'b0, ack_o},   32'd1);
        idle(1);
        chk("drain0_q_o", q_o, 32'h11);
        idle(1);
        chk("drain1_q_o", q_o, 32'h22);
        idle(1);
        chk("drain_empty_o", {31'b0, empty_o}, 32'd1);
        chk("drain_ack_o",   {31'b0, ack_o},   32'd0);

        // flush with two requests in flight
        cyc(1, 0, 32'h0, 0, 1, 0);
        cyc(1, 0, 32'h0, 0, 1, 0);
        cyc(0, 0, 32'h0, 0, 1, 1);
        chk("flush_clr_ack_o", {31'b0, ack_o},   32'd0);
        chk("flush_ready_o",   {31'b0, ready_o}, 32'd0);
        cyc(0, 1, 32'hAA, 0, 1, 0);
        chk("flush_drop0_ack_o", {31'b0, ack_o}, 32'd0);
        cyc(0, 1, 32'hBB, 0, 1, 0);
        chk("flush_drop1_ack_o", {31'b0, ack_o}, 32'd0);
        idle(1);
        chk("flush_after_ready_o", {31'b0, ready_o}, 32'd1);
        cyc(1, 0, 32'h0, 0, 1, 0);
        exp_q.push_back({1'b0, 32'hCC});
        cyc(0, 1, 32'hCC, 0, 1, 0);
        chk("flush_follow_ack_o", {31'b0, ack_o}, 32'd1);

        // clr coincident with req and ack
        cyc(1, 0, 32'h0, 0, 1, 0);
        cyc(1, 1, 32'h77, 0, 1, 1);
        chk("coinc_ack_o", {31'b0, ack_o}, 32'd0);
        cyc(0, 1, 32'h55, 0, 1, 0);
        chk("coinc_drop_ack_o", {31'b0, ack_o}, 32'd0);
        idle(1);
        chk("coinc_ready_o", {31'b0, ready_o}, 32'd1);
        cyc(1, 0, 32'h0, 0, 1, 0);
        exp_q.push_back({1'b0, 32'h66});
        cyc(0, 1, 32'h66, 0, 1, 0);
        chk("coinc_follow_ack_o", {31'b0, ack_o}, 32'd1);

        // error propagation through the queue
        cyc(1, 0, 32'h0, 0, 0, 0);
        cyc(1, 0, 32'h0, 0, 0, 0);
        exp_q.push_back({1'b0, 32'h01});
        cyc(0, 1, 32'h01, 0, 0, 0);
        exp_q.push_back({1'b1, 32'h02});
        cyc(0, 1, 32'h02, 1, 0, 0);
        idle(1);
        chk("err_first_err_o", {31'b0, err_o}, 32'd0);
        idle(1);
        chk("err_second_err_o", {31'b0, err_o}, 32'd1);
        idle(1);

        // back-to-back streaming
        cyc(1, 0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({1'b0, 32'h100 + 32'(i)});
            cyc((i < 15) ? 1'b1 : 1'b0, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b1, 1'b0);
            chk("stream_ack_o",   {31'b0, ack_o},   32'd1);
            chk("stream_empty_o", {31'b0, empty_o}, 32'd1);
        end
        idle(1);
        chk("stream_ready_o", {31'b0, ready_o}, 32'd1);
        chk("exp_q_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
